// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Produces the registered 10-bit micro-address (upc) for a combinational
//   microcode ROM. It decodes instruction bytes from fetch, including the
//   CB prefix page. It steps through micro-sequences using the ROM's
//   next/flow bits, and it handles interrupt dispatch and HALT.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   ibyte/ibyte_valid    instruction byte from fetch
//   ibyte_ready          byte accepted this cycle (FETCH without irq, PREFIX)
//   irq_pending, ime     pending enabled interrupt, master enable
//   uc_next/last/cond    flow fields of the control word at upc
//   cond_true            condition result for uc_cond
//   uc_mem_wait/mem_done memory stall handshake for the current step
//   uc_halt              current step is HALT
//   upc/upc_valid        ROM address, valid while executing
//   irq_ack              one-cycle pulse on the first IRQ_ENTRY cycle
//   halted               sequencer is halted
module microcode_sequencer #(
  parameter logic [9:0] IRQ_ENTRY = 10'h200,
  parameter logic [9:0] IDLE_ADDR = 10'h000,
  parameter logic [7:0] CB_BYTE   = 8'hCB
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ibyte,
  input  logic       ibyte_valid,
  output logic       ibyte_ready,
  input  logic       irq_pending,
  input  logic       ime,
  input  logic [9:0] uc_next,
  input  logic       uc_last,
  input  logic       uc_cond,
  input  logic       cond_true,
  input  logic       uc_mem_wait,
  input  logic       mem_done,
  input  logic       uc_halt,
  output logic [9:0] upc,
  output logic       upc_valid,
  output logic       irq_ack,
  output logic       halted
);

  typedef enum logic [1:0] {FETCH, PREFIX, EXEC, HALT} state_t;

  state_t     state, state_n;
  logic [9:0] upc_n;
  logic       ack_n;
  logic       take_irq;

  assign take_irq    = irq_pending && ime;
  assign ibyte_ready = ((state == FETCH) && !take_irq) || (state == PREFIX);
  assign halted      = (state == HALT);
  assign upc_valid   = (state == EXEC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      upc     <= IDLE_ADDR;
      irq_ack <= 1'b0;
    end else begin
      state   <= state_n;
      upc     <= upc_n;
      irq_ack <= ack_n;
    end
  end

  always_comb begin
    state_n = state;
    upc_n   = upc;
    ack_n   = 1'b0;
    case (state)
      FETCH: begin
        // Interrupt wins over a waiting byte; the byte stays with fetch.
        if (take_irq) begin
          state_n = EXEC;
          upc_n   = IRQ_ENTRY;
          ack_n   = 1'b1;
        end else if (ibyte_valid) begin
          if (ibyte == CB_BYTE) begin
            state_n = PREFIX;
            upc_n   = IDLE_ADDR;
          end else begin
            state_n = EXEC;
            upc_n   = {2'b00, ibyte};
          end
        end
      end
      PREFIX: begin
        // Prefix + opcode are atomic: no interrupt check between them.
        if (ibyte_valid) begin
          state_n = EXEC;
          upc_n   = {2'b01, ibyte};
        end
      end
      EXEC: begin
        if (uc_mem_wait && !mem_done) begin
          upc_n = upc;
        end else if ((uc_cond && !cond_true) || (!uc_halt && uc_last)) begin
          // Instruction boundary: dispatch back-to-back or return to fetch.
          if (take_irq) begin
            upc_n = IRQ_ENTRY;
            ack_n = 1'b1;
          end else begin
            state_n = FETCH;
            upc_n   = IDLE_ADDR;
          end
        end else if (uc_halt) begin
          state_n = HALT;
          upc_n   = IDLE_ADDR;
        end else begin
          upc_n = uc_next;
        end
      end
      HALT: begin
        // A pending interrupt always wakes; it dispatches only with ime.
        if (irq_pending) begin
          if (ime) begin
            state_n = EXEC;
            upc_n   = IRQ_ENTRY;
            ack_n   = 1'b1;
          end else begin
            state_n = FETCH;
            upc_n   = IDLE_ADDR;
          end
        end
      end
      default: begin
        state_n = FETCH;
        upc_n   = IDLE_ADDR;
      end
    endcase
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ibyte;
  logic       ibyte_valid, ibyte_ready, irq_pending, ime;
  logic [9:0] uc_next;
  logic       uc_last, uc_cond, cond_true, uc_mem_wait, mem_done, uc_halt;
  logic [9:0] upc;
  logic       upc_valid, irq_ack, halted;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk(clk), .reset(reset), .ibyte(ibyte), .ibyte_valid(ibyte_valid),
    .ibyte_ready(ibyte_ready), .irq_pending(irq_pending), .ime(ime),
    .uc_next(uc_next), .uc_last(uc_last), .uc_cond(uc_cond),
    .cond_true(cond_true), .uc_mem_wait(uc_mem_wait), .mem_done(mem_done),
    .uc_halt(uc_halt), .upc(upc), .upc_valid(upc_valid), .irq_ack(irq_ack),
    .halted(halted)
  );

  // input flags
  localparam int R = 1, V = 2, I = 4, E = 8, L = 16, C = 32, T = 64, W = 128, D = 256, H = 512;
  // expected output flags after the edge
  localparam int OV = 1, OA = 2, OH = 4, OR = 8;
  localparam int SKIP = 2;

  typedef struct {
    int         fl;
    logic [7:0] ib;
    logic [9:0] nxt;
    int         pre;   // expected ibyte_ready before the edge, or SKIP
    logic [9:0] eupc;
    int         eo;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(int fl, logic [7:0] ib, logic [9:0] nxt, int pre, logic [9:0] eupc, int eo);
    vec_t v;
    v.fl = fl; v.ib = ib; v.nxt = nxt; v.pre = pre; v.eupc = eupc; v.eo = eo;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [9:0] act, logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(int fl, logic [7:0] ib, logic [9:0] nxt);
    reset       = (fl & R) != 0;
    ibyte_valid = (fl & V) != 0;
    irq_pending = (fl & I) != 0;
    ime         = (fl & E) != 0;
    uc_last     = (fl & L) != 0;
    uc_cond     = (fl & C) != 0;
    cond_true   = (fl & T) != 0;
    uc_mem_wait = (fl & W) != 0;
    mem_done    = (fl & D) != 0;
    uc_halt     = (fl & H) != 0;
    ibyte       = ib;
    uc_next     = nxt;
  endtask

  task automatic post(string tag, int idx, logic [9:0] eupc, int eo);
    chk({tag, " upc"}, idx, upc, eupc);
    chk({tag, " upc_valid"}, idx, {9'd0, upc_valid}, {9'd0, (eo & OV) != 0});
    chk({tag, " irq_ack"}, idx, {9'd0, irq_ack}, {9'd0, (eo & OA) != 0});
    chk({tag, " halted"}, idx, {9'd0, halted}, {9'd0, (eo & OH) != 0});
    chk({tag, " ibyte_ready"}, idx, {9'd0, ibyte_ready}, {9'd0, (eo & OR) != 0});
  endtask

  initial begin
    drive(0, 8'h00, 10'h000);
    // reset
    vecs.push_back(mk(R,         8'h00, 10'h000, SKIP, 10'h000, OR));       // 0
    // basic instruction
    vecs.push_back(mk(V,         8'h3E, 10'h000, 1, 10'h03E, OV));          // 1
    vecs.push_back(mk(0,         8'h00, 10'h210, 0, 10'h210, OV));          // 2
    vecs.push_back(mk(L,         8'h00, 10'h000, 0, 10'h000, OR));          // 3
    // CB prefix
    vecs.push_back(mk(V,         8'hCB, 10'h000, 1, 10'h000, OR));          // 4
    vecs.push_back(mk(V,         8'h37, 10'h000, 1, 10'h137, OV));          // 5
    // memory stall
    vecs.push_back(mk(W,         8'h00, 10'h155, 0, 10'h137, OV));          // 6
    vecs.push_back(mk(W,         8'h00, 10'h155, 0, 10'h137, OV));          // 7
    vecs.push_back(mk(W,         8'h00, 10'h155, 0, 10'h137, OV));          // 8
    vecs.push_back(mk(W|D,       8'h00, 10'h155, 0, 10'h155, OV));          // 9
    vecs.push_back(mk(L,         8'h00, 10'h000, 0, 10'h000, OR));          // 10
    // conditional abort / continue
    vecs.push_back(mk(V,         8'h20, 10'h000, 1, 10'h020, OV));          // 11
    vecs.push_back(mk(C,         8'h00, 10'h300, 0, 10'h000, OR));          // 12
    vecs.push_back(mk(V,         8'h20, 10'h000, 1, 10'h020, OV));          // 13
    vecs.push_back(mk(C|T,       8'h00, 10'h300, 0, 10'h300, OV));          // 14
    vecs.push_back(mk(C|H,       8'h00, 10'h000, 0, 10'h000, OR));          // 15 abort beats halt
    // interrupts
    vecs.push_back(mk(V,         8'h01, 10'h000, 1, 10'h001, OV));          // 16
    vecs.push_back(mk(L|I|E,     8'h00, 10'h000, 0, 10'h200, OV|OA));       // 17 back-to-back
    vecs.push_back(mk(0,         8'h00, 10'h201, 0, 10'h201, OV));          // 18
    vecs.push_back(mk(L,         8'h00, 10'h000, 0, 10'h000, OR));          // 19
    vecs.push_back(mk(V|I|E,     8'h05, 10'h000, 0, 10'h200, OV|OA));       // 20 irq over byte
    vecs.push_back(mk(W,         8'h00, 10'h000, 0, 10'h200, OV));          // 21 ack not repeated
    vecs.push_back(mk(L,         8'h00, 10'h000, 0, 10'h000, OR));          // 22
    vecs.push_back(mk(V|I,       8'h06, 10'h000, 1, 10'h006, OV));          // 23 ime=0
    // HALT
    vecs.push_back(mk(H,         8'h00, 10'h000, 0, 10'h000, OH));          // 24
    vecs.push_back(mk(0,         8'h00, 10'h000, 0, 10'h000, OH));          // 25
    vecs.push_back(mk(I,         8'h00, 10'h000, 0, 10'h000, OR));          // 26 wake, no dispatch
    vecs.push_back(mk(V,         8'h07, 10'h000, 1, 10'h007, OV));          // 27
    vecs.push_back(mk(H|L,       8'h00, 10'h000, 0, 10'h000, OH));          // 28 halt beats last
    vecs.push_back(mk(I|E,       8'h00, 10'h000, 0, 10'h200, OV|OA));       // 29
    vecs.push_back(mk(0,         8'h00, 10'h222, 0, 10'h222, OV));          // 30
    vecs.push_back(mk(R|V,       8'h08, 10'h3FF, 0, 10'h000, OR));          // 31 reset in EXEC
    // stall priority over abort
    vecs.push_back(mk(V,         8'h09, 10'h000, 1, 10'h009, OV));          // 32
    vecs.push_back(mk(W|C,       8'h00, 10'h000, 0, 10'h009, OV));          // 33
    vecs.push_back(mk(W|D|L,     8'h00, 10'h000, 0, 10'h000, OR));          // 34
    // prefix is atomic w.r.t. interrupts
    vecs.push_back(mk(V,         8'hCB, 10'h000, 1, 10'h000, OR));          // 35
    vecs.push_back(mk(I|E,       8'h00, 10'h000, 1, 10'h000, OR));          // 36
    vecs.push_back(mk(V|I|E,     8'h40, 10'h000, 1, 10'h140, OV));          // 37
    vecs.push_back(mk(L,         8'h00, 10'h000, 0, 10'h000, OR));          // 38

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].ib, vecs[i].nxt);
      #1;
      if (vecs[i].pre != SKIP)
        chk("pre ibyte_ready", i, {9'd0, ibyte_ready}, {9'd0, vecs[i].pre == 1});
      @(posedge clk);
      #1;
      post("vec", i, vecs[i].eupc, vecs[i].eo);
    end

    // Hand sequence: HALT held many cycles, then dispatch during a long
    // stall at IRQ_ENTRY; irq_ack must pulse exactly once.
    @(negedge clk); drive(V, 8'h11, 10'h000);
    @(posedge clk); #1; post("hs enter", 0, 10'h011, OV);
    @(negedge clk); drive(H, 8'h00, 10'h000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; post("hs halt", k, 10'h000, OH);
      @(negedge clk); drive(0, 8'h00, 10'h000);
    end
    drive(I|E, 8'h00, 10'h000);
    @(posedge clk); #1; post("hs wake", 0, 10'h200, OV|OA);
    @(negedge clk); drive(W, 8'h00, 10'h000);
    begin
      int acks = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (irq_ack) acks++;
        chk("hs stall upc", k, upc, 10'h200);
      end
      chk("hs ack count", 0, acks[9:0], 10'd0);
    end
    @(negedge clk); drive(W|D, 8'h00, 10'h2A5);
    @(posedge clk); #1; post("hs resume", 0, 10'h2A5, OV);

    // Hand sequence: reset while in PREFIX.
    @(negedge clk); drive(L, 8'h00, 10'h000);
    @(posedge clk); #1; post("hs fetch", 0, 10'h000, OR);
    @(negedge clk); drive(V, 8'hCB, 10'h000);
    @(posedge clk); #1; post("hs prefix", 0, 10'h000, OR);
    @(negedge clk); drive(R, 8'h00, 10'h000);
    @(posedge clk); #1; post("hs rst", 0, 10'h000, OR);
    @(negedge clk); drive(V, 8'h37, 10'h000);
    @(posedge clk); #1; post("hs after rst", 0, 10'h037, OV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
